pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_pkg.sv | 33 +++
 rtl/pwm_tick_gen.sv | 27 ++
 rtl/pwm_ramp_ctrl.sv | 158 +++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM soft-start / reversal ramp controller.
package pwm_pkg;

  localparam int DUTY_W          = 7;
  localparam int DEF_RAMP_DIV    = 1000;
  localparam int DEF_DUTY_STEP   = 1;
  localparam int DEF_DEAD_CYCLES = 5000;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    DEAD = 2'd3
  } state_t;

  // Move cur toward tgt by at most step, never overshooting tgt.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W-1:0] res;
    if (cur < tgt) begin
      res = ((tgt - cur) > step) ? (cur + step) : tgt;
    end else if (cur > tgt) begin
      res = ((cur - tgt) > step) ? (cur - step) : tgt;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Ramp prescaler: counts 0..div-1 and flags the terminal count as a tick.
module pwm_tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] count_r;

  assign tick = (count_r == (div - 16'd1));

  // Prescaler counter with wrap at the terminal count and restart on clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= 16'd0;
    end else if (clr) begin
      count_r <= 16'd0;
    end else if (tick) begin
      count_r <= 16'd0;
    end else begin
      count_r <= count_r + 16'd1;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty ramp controller: soft start/stop, retargeting and dead-timed direction reversal.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int RAMP_DIV    = DEF_RAMP_DIV,
  parameter int DUTY_STEP   = DEF_DUTY_STEP,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  input  logic [DUTY_W-1:0] i_cmd_duty,
  input  logic              i_cmd_dir,
  input  logic              i_cmd_on,
  output logic              o_cmd_ready,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_duty_en,
  output logic              o_direction,
  output logic              o_on_off,
  output logic              o_at_target
);

  localparam logic [DUTY_W-1:0] STEP_C = DUTY_W'(DUTY_STEP);
  localparam logic [15:0]       DEAD_C = 16'(DEAD_CYCLES);
  localparam logic [15:0]       DIV_C  = 16'(RAMP_DIV);

  state_t            state_r, state_s;
  logic [DUTY_W-1:0] cur_r, cur_s;
  logic [DUTY_W-1:0] tgt_r, tgt_s;
  logic              pend_dir_r, pend_dir_s;
  logic              pend_off_r, pend_off_s;
  logic [15:0]       dead_r, dead_s;
  logic              dir_r, dir_s;
  logic              on_r, on_s;
  logic              duty_en_r;
  logic              at_target_r;
  logic              tick_s;
  logic              clr_s;
  logic              accept_s;

  pwm_tick_gen u_tick (
    .clk  (i_sys_clk),
    .rst  (i_rst),
    .clr  (clr_s),
    .div  (DIV_C),
    .tick (tick_s)
  );

  assign o_cmd_ready = (state_r == OFF) || (state_r == RUN);
  assign accept_s    = i_cmd_valid && o_cmd_ready;
  assign o_duty      = cur_r;
  assign o_duty_en   = duty_en_r;
  assign o_direction = dir_r;
  assign o_on_off    = on_r;
  assign o_at_target = at_target_r;

  // Next-state, ramp arithmetic and dead-time countdown.
  always_comb begin
    state_s    = state_r;
    cur_s      = cur_r;
    tgt_s      = tgt_r;
    pend_dir_s = pend_dir_r;
    pend_off_s = pend_off_r;
    dead_s     = dead_r;
    dir_s      = dir_r;
    on_s       = on_r;
    clr_s      = 1'b0;
    case (state_r)
      OFF: begin
        if (accept_s && i_cmd_on) begin
          state_s = RUN;
          tgt_s   = i_cmd_duty;
          dir_s   = i_cmd_dir;
          on_s    = 1'b1;
          clr_s   = 1'b1;
        end else begin
          state_s = OFF;
        end
      end
      RUN: begin
        if (tick_s) begin
          cur_s = step_toward(cur_r, tgt_r, STEP_C);
        end else begin
          cur_s = cur_r;
        end
        if (!accept_s) begin
          state_s = RUN;
        end else if (!i_cmd_on) begin
          pend_off_s = 1'b1;
          state_s    = STOP;
        end else if (i_cmd_dir != dir_r) begin
          pend_dir_s = i_cmd_dir;
          tgt_s      = i_cmd_duty;
          pend_off_s = 1'b0;
          state_s    = STOP;
        end else begin
          tgt_s = i_cmd_duty;
        end
      end
      STOP: begin
        if (cur_r != {DUTY_W{1'b0}}) begin
          if (tick_s) begin
            cur_s = step_toward(cur_r, {DUTY_W{1'b0}}, STEP_C);
          end else begin
            cur_s = cur_r;
          end
        end else if (pend_off_r) begin
          state_s = OFF;
          on_s    = 1'b0;
        end else begin
          state_s = DEAD;
          dead_s  = DEAD_C;
        end
      end
      DEAD: begin
        // Direction only flips here, with duty already held at zero.
        if (dead_r == 16'd0) begin
          dir_s   = pend_dir_r;
          state_s = RUN;
          clr_s   = 1'b1;
        end else begin
          dead_s = dead_r - 16'd1;
        end
      end
      default: begin
        state_s = OFF;
      end
    endcase
  end

  // Registered state and outputs; strobe and at-target derive from next values.
  always_ff @(posedge i_sys_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r     <= OFF;
      cur_r       <= {DUTY_W{1'b0}};
      tgt_r       <= {DUTY_W{1'b0}};
      pend_dir_r  <= 1'b0;
      pend_off_r  <= 1'b0;
      dead_r      <= 16'd0;
      dir_r       <= 1'b0;
      on_r        <= 1'b0;
      duty_en_r   <= 1'b0;
      at_target_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_r       <= cur_s;
      tgt_r       <= tgt_s;
      pend_dir_r  <= pend_dir_s;
      pend_off_r  <= pend_off_s;
      dead_r      <= dead_s;
      dir_r       <= dir_s;
      on_r        <= on_s;
      duty_en_r   <= (cur_s != cur_r);
      at_target_r <= (state_s == RUN) && (cur_s == tgt_s);
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed soft-start/retarget/reversal/stop/reset scenarios plus random commands.
module tb_pwm_ramp_ctrl;

  localparam int DIV   = 4;
  localparam int STEP  = 8;
  localparam int DEADC = 10;

  localparam int M_OFF  = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;
  localparam int M_DEAD = 3;

  logic       clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic [6:0] i_cmd_duty = 7'd0;
  logic       i_cmd_dir = 1'b0;
  logic       i_cmd_on = 1'b0;
  logic       o_cmd_ready;
  logic [6:0] o_duty;
  logic       o_duty_en;
  logic       o_direction;
  logic       o_on_off;
  logic       o_at_target;

  pwm_ramp_ctrl #(.RAMP_DIV(DIV), .DUTY_STEP(STEP), .DEAD_CYCLES(DEADC)) dut (
    .i_sys_clk   (clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_duty  (i_cmd_duty),
    .i_cmd_dir   (i_cmd_dir),
    .i_cmd_on    (i_cmd_on),
    .o_cmd_ready (o_cmd_ready),
    .o_duty      (o_duty),
    .o_duty_en   (o_duty_en),
    .o_direction (o_direction),
    .o_on_off    (o_on_off),
    .o_at_target (o_at_target)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model: mode, duty, target, direction; ticks derived from the last prescaler restart.
  int cyc = 0;
  int m_mode, m_duty, m_tgt, m_dir, m_on, m_pdir, m_poff, m_strobe, m_at;
  int m_rs, m_dead_until;

  int cap_q[$];
  int capc_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_mode = M_OFF; m_duty = 0; m_tgt = 0; m_dir = 0; m_on = 0;
    m_pdir = 0; m_poff = 0; m_strobe = 0; m_at = 0;
    m_rs = cyc; m_dead_until = 0;
  endtask

  task automatic model_step();
    int nd;
    bit acc, tick, restart;
    acc = i_cmd_valid && (m_mode == M_OFF || m_mode == M_RUN);
    tick = ((cyc - m_rs) % DIV) == (DIV - 1);
    restart = 1'b0;
    nd = m_duty;
    case (m_mode)
      M_OFF: begin
        if (acc && i_cmd_on) begin
          m_mode = M_RUN; m_tgt = i_cmd_duty; m_dir = i_cmd_dir; m_on = 1; restart = 1'b1;
        end
      end
      M_RUN: begin
        if (tick && m_duty < m_tgt) nd = m_duty + imin(STEP, m_tgt - m_duty);
        if (tick && m_duty > m_tgt) nd = m_duty - imin(STEP, m_duty - m_tgt);
        if (acc) begin
          if (!i_cmd_on) begin
            m_poff = 1; m_mode = M_STOP;
          end else if (int'(i_cmd_dir) != m_dir) begin
            m_pdir = i_cmd_dir; m_tgt = i_cmd_duty; m_poff = 0; m_mode = M_STOP;
          end else begin
            m_tgt = i_cmd_duty;
          end
        end
      end
      M_STOP: begin
        if (m_duty == 0) begin
          if (m_poff != 0) begin
            m_mode = M_OFF; m_on = 0;
          end else begin
            m_mode = M_DEAD; m_dead_until = cyc + 1 + DEADC;
          end
        end else if (tick) begin
          nd = m_duty - imin(STEP, m_duty);
        end
      end
      M_DEAD: begin
        if (cyc == m_dead_until) begin
          m_dir = m_pdir; m_mode = M_RUN; restart = 1'b1;
        end
      end
      default: ;
    endcase
    m_strobe = (nd != m_duty);
    m_duty = nd;
    m_at = (m_mode == M_RUN) && (m_duty == m_tgt);
    if (restart) m_rs = cyc + 1;
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    chk("duty", o_duty, m_duty);
    chk("duty_en", o_duty_en, m_strobe);
    chk("direction", o_direction, m_dir);
    chk("on_off", o_on_off, m_on);
    chk("at_target", o_at_target, m_at);
    chk("cmd_ready", o_cmd_ready, (m_mode == M_OFF || m_mode == M_RUN) ? 1 : 0);
    if (o_duty_en) begin
      cap_q.push_back(o_duty);
      capc_q.push_back(cyc);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic cmd(input bit on, input bit dir, input int duty);
    i_cmd_valid = 1'b1; i_cmd_on = on; i_cmd_dir = dir; i_cmd_duty = 7'(duty);
    cycle();
    i_cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_duty"}, o_duty, 0);
    chk({tag, "_duty_en"}, o_duty_en, 0);
    chk({tag, "_dir"}, o_direction, 0);
    chk({tag, "_on_off"}, o_on_off, 0);
    chk({tag, "_at_target"}, o_at_target, 0);
    chk({tag, "_ready"}, o_cmd_ready, 1);
  endtask

  // Assert reset between edges, check outputs immediately, release on a falling edge.
  task automatic do_reset(input string tag);
    #2 i_rst = 1'b0;
    #1 chk_reset_vals(tag);
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    model_reset();
  endtask

  task automatic chk_cap(input string name, input int exp[$]);
    chk({name, "_count"}, cap_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap_q.size(); i++) chk(name, cap_q[i], exp[i]);
  endtask

  initial begin
    int low_cnt, bad_cnt;
    bit counting, done;
    #1 chk_reset_vals("por");
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    model_reset();
    run(3);

    // Off command while OFF is ignored.
    cmd(1'b0, 1'b1, 50);
    run(4);

    // Soft start to 20 clockwise.
    cap_q.delete(); capc_q.delete();
    cmd(1'b1, 1'b1, 20);
    chk("start_on_off", o_on_off, 1);
    chk("start_duty0", o_duty, 0);
    run(20);
    chk_cap("start_seq", '{8, 16, 20});
    if (capc_q.size() == 3) begin
      chk("start_gap1", capc_q[1] - capc_q[0], 4);
      chk("start_gap2", capc_q[2] - capc_q[1], 4);
    end
    chk("start_at_target", o_at_target, 1);

    // Retarget down to 5.
    cap_q.delete(); capc_q.delete();
    cmd(1'b1, 1'b1, 5);
    run(20);
    chk_cap("retarget_seq", '{12, 5});
    chk("retarget_at_target", o_at_target, 1);

    cmd(1'b1, 1'b1, 20);
    run(20);

    // Reversal to counterclockwise at 16.
    cap_q.delete(); capc_q.delete();
    low_cnt = 0; bad_cnt = 0; counting = 1'b0; done = 1'b0;
    cmd(1'b1, 1'b0, 16);
    chk("rev_ready_low", o_cmd_ready, 0);
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (counting) begin
        if (!o_cmd_ready) begin
          low_cnt++;
          if (!(o_on_off && o_direction)) bad_cnt++;
        end else begin
          counting = 1'b0;
        end
      end
      if (o_duty_en && o_duty == 7'd0 && !done) begin
        counting = 1'b1;
        done = 1'b1;
      end
    end
    chk_cap("rev_seq", '{12, 4, 0, 8, 16});
    chk("rev_dead_cycles", low_cnt, 11);
    chk("rev_dead_outputs", bad_cnt, 0);
    if (capc_q.size() == 5) chk("rev_restart_gap", capc_q[3] - capc_q[2], 16);
    chk("rev_final_dir", o_direction, 0);

    // Back to 20, then stop with a busy-time command offered.
    cmd(1'b1, 1'b0, 20);
    run(10);
    cap_q.delete(); capc_q.delete();
    cmd(1'b0, 1'b0, 0);
    i_cmd_valid = 1'b1; i_cmd_on = 1'b1; i_cmd_dir = 1'b1; i_cmd_duty = 7'd100;
    run(2);
    i_cmd_valid = 1'b0;
    run(20);
    chk_cap("stop_seq", '{12, 4, 0});
    chk("stop_on_off", o_on_off, 0);
    chk("stop_ready", o_cmd_ready, 1);
    chk("stop_dir_kept", o_direction, 0);

    // Reset during the dead time of a reversal.
    cmd(1'b1, 1'b1, 10);
    run(12);
    cmd(1'b1, 1'b0, 30);
    run(12);
    chk("dead_pre_ready", o_cmd_ready, 0);
    chk("dead_pre_duty", o_duty, 0);
    chk("dead_pre_on", o_on_off, 1);
    do_reset("dead_rst");
    cap_q.delete(); capc_q.delete();
    run(20);
    chk("post_reset_strobes", cap_q.size(), 0);

    // Random command traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      i_cmd_valid = ($urandom_range(0, 7) == 0);
      i_cmd_duty  = 7'($urandom_range(0, 127));
      i_cmd_dir   = 1'($urandom_range(0, 1));
      i_cmd_on    = ($urandom_range(0, 5) != 0);
      cycle();
      if ($urandom_range(0, 599) == 0) do_reset("rand_rst");
    end
    i_cmd_valid = 1'b0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
